// File: rtl/tmr_fault_monitor.sv
// Fault monitor for the triplicated counter: per-replica health FSMs, saturating
// error counts and an event FIFO. Define TMR_MON_TSTAMP_EN to add per-event cycle timestamps.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_OK      | replica agrees with the vote
// ST_SUSPECT | replica faulty for fewer than PERSIST_CYCLES enabled cycles
// ST_FAILED  | replica faulty PERSIST_CYCLES in a row; sticky until clr/reset
module tmr_fault_monitor #(
    parameter int WIDTH          = 128,
    parameter int FIFO_DEPTH     = 4,
    parameter int PERSIST_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [2:0]           fault,
    input  logic [WIDTH-1:0]     voted_q,
    input  logic                 clr,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [2:0]           evt_mask,
    output logic [WIDTH-1:0]     evt_value,
    output logic                 evt_uncorr,
    output logic [2:0]           replica_failed,
    output logic [3*CNT_W-1:0]   err_cnt,
    output logic                 uncorr_sticky,
    output logic                 ovf_sticky
`ifdef TMR_MON_TSTAMP_EN
    ,
    output logic [31:0]          evt_tstamp
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [7:0]       PERSIST_LOAD = 8'(PERSIST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX      = {CNT_W{1'b1}};
    localparam logic [PTR_W:0]   DEPTH_C      = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAILED  = 2'd2
    } rep_state_t;

    rep_state_t       state_r   [3];
    logic [7:0]       persist_r [3];
    logic [CNT_W-1:0] err_r     [3];

    logic [2:0]       fault_q;
    logic             evt_gen;
    logic             fifo_full;
    logic             push;
    logic             pop;

    logic [2:0]       mask_mem   [FIFO_DEPTH];
    logic [WIDTH-1:0] value_mem  [FIFO_DEPTH];
    logic             uncorr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_r;

    // persist_r counts down the remaining faulty cycles before the replica fails
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i]   <= ST_OK;
                persist_r[i] <= '0;
                err_r[i]     <= '0;
            end
            replica_failed <= '0;
        end else if (clr) begin
            for (int i = 0; i < 3; i++) begin
                state_r[i]   <= ST_OK;
                persist_r[i] <= '0;
                err_r[i]     <= '0;
            end
            replica_failed <= '0;
        end else if (enable) begin
            for (int i = 0; i < 3; i++) begin
                if (fault[i] && (err_r[i] != ERR_MAX)) begin
                    err_r[i] <= err_r[i] + 1'b1;
                end
                case (state_r[i])
                    ST_OK: begin
                        if (fault[i]) begin
                            state_r[i]   <= ST_SUSPECT;
                            persist_r[i] <= PERSIST_LOAD;
                        end
                    end
                    ST_SUSPECT: begin
                        if (!fault[i]) begin
                            state_r[i]   <= ST_OK;
                            persist_r[i] <= '0;
                        end else if (persist_r[i] == 8'd1) begin
                            state_r[i]        <= ST_FAILED;
                            persist_r[i]      <= '0;
                            replica_failed[i] <= 1'b1;
                        end else begin
                            persist_r[i] <= persist_r[i] - 8'd1;
                        end
                    end
                    ST_FAILED: begin
                        state_r[i] <= ST_FAILED;
                    end
                    default: begin
                        state_r[i]   <= ST_OK;
                        persist_r[i] <= '0;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_err
        assign err_cnt[g*CNT_W +: CNT_W] = err_r[g];
    end

    assign evt_gen   = enable && ((fault & ~fault_q) != 3'b000);
    assign fifo_full = (count_r == DEPTH_C);
    assign pop       = (count_r != '0) && evt_ready;
    // a pop on the same edge frees the slot the push needs
    assign push      = evt_gen && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mask_mem[j]   <= '0;
                value_mem[j]  <= '0;
                uncorr_mem[j] <= 1'b0;
            end
        end else begin
            if (enable) begin
                fault_q <= fault;
            end
            if (push) begin
                mask_mem[wr_ptr]   <= fault;
                value_mem[wr_ptr]  <= voted_q;
                uncorr_mem[wr_ptr] <= (fault == 3'b111);
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uncorr_sticky <= 1'b0;
            ovf_sticky    <= 1'b0;
        end else if (clr) begin
            uncorr_sticky <= 1'b0;
            ovf_sticky    <= 1'b0;
        end else begin
            if (enable && (fault == 3'b111)) begin
                uncorr_sticky <= 1'b1;
            end
            if (evt_gen && fifo_full && !pop) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

    assign evt_valid  = (count_r != '0);
    assign evt_mask   = mask_mem[rd_ptr];
    assign evt_value  = value_mem[rd_ptr];
    assign evt_uncorr = uncorr_mem[rd_ptr];

`ifdef TMR_MON_TSTAMP_EN
    logic [31:0] tstamp_r;
    logic [31:0] ts_mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstamp_r <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                ts_mem[j] <= '0;
            end
        end else begin
            tstamp_r <= tstamp_r + 32'd1;
            if (push) begin
                ts_mem[wr_ptr] <= tstamp_r;
            end
        end
    end

    assign evt_tstamp = ts_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Scoreboard bench for tmr_fault_monitor: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT hands them over.
module tb_tmr_fault_monitor;

    localparam int WIDTH = 128;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic [2:0]         fault;
    logic [WIDTH-1:0]   voted_q;
    logic               clr;
    logic               evt_valid;
    logic               evt_ready;
    logic [2:0]         evt_mask;
    logic [WIDTH-1:0]   evt_value;
    logic               evt_uncorr;
    logic [2:0]         replica_failed;
    logic [3*CNT_W-1:0] err_cnt;
    logic               uncorr_sticky;
    logic               ovf_sticky;
`ifdef TMR_MON_TSTAMP_EN
    logic [31:0]        evt_tstamp;
`endif

    tmr_fault_monitor #(
        .WIDTH(WIDTH), .FIFO_DEPTH(4), .PERSIST_CYCLES(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault),
        .voted_q(voted_q), .clr(clr), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_mask(evt_mask), .evt_value(evt_value),
        .evt_uncorr(evt_uncorr), .replica_failed(replica_failed),
        .err_cnt(err_cnt), .uncorr_sticky(uncorr_sticky),
        .ovf_sticky(ovf_sticky)
`ifdef TMR_MON_TSTAMP_EN
        , .evt_tstamp(evt_tstamp)
`endif
    );

    typedef struct {
        logic [2:0]       mask;
        logic [WIDTH-1:0] value;
        logic             uncorr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic [2:0] m, input logic [WIDTH-1:0] v);
        exp_t e;
        e.mask   = m;
        e.value  = v;
        e.uncorr = (m == 3'b111);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            exp_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_evt: got mask %b value %0h, none expected",
                         evt_mask, evt_value);
            end else begin
                e = exp_q.pop_front();
                if (evt_mask !== e.mask || evt_value !== e.value || evt_uncorr !== e.uncorr) begin
                    n_fail++;
                    $display("FAIL evt_payload: got %b/%0h/%b expected %b/%0h/%b",
                             evt_mask, evt_value, evt_uncorr, e.mask, e.value, e.uncorr);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; fault = 3'b000; voted_q = '0;
        clr = 1'b0; evt_ready = 1'b0;
        tick(2);
        check("rst_evt_valid", WIDTH'(evt_valid), '0);
        check("rst_err_cnt", WIDTH'(err_cnt), '0);
        check("rst_failed", WIDTH'(replica_failed), '0);
        check("rst_stickies", WIDTH'({uncorr_sticky, ovf_sticky}), '0);
        rst_n = 1'b1;

        // single glitch
        evt_ready = 1'b1; enable = 1'b1;
        fault = 3'b001; voted_q = 'h10; expect_evt(3'b001, 'h10);
        tick();
        fault = 3'b000;
        tick();
        check("glitch_err_cnt", WIDTH'(err_cnt), WIDTH'(24'h000001));
        check("glitch_failed", WIDTH'(replica_failed), '0);

        // persistence
        fault = 3'b010; voted_q = 'h20; expect_evt(3'b010, 'h20);
        tick(7);
        check("persist_7_failed", WIDTH'(replica_failed), '0);
        tick();
        check("persist_8_failed", WIDTH'(replica_failed), WIDTH'(3'b010));
        check("persist_err_cnt", WIDTH'(err_cnt), WIDTH'(24'h000801));
        fault = 3'b000;
        tick(2);
        check("failed_sticky", WIDTH'(replica_failed), WIDTH'(3'b010));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_failed", WIDTH'(replica_failed), '0);
        check("clr_err_cnt", WIDTH'(err_cnt), '0);

        // enable gating
        enable = 1'b0; fault = 3'b100;
        tick(20);
        check("gate_err_cnt", WIDTH'(err_cnt), '0);
        check("gate_failed", WIDTH'(replica_failed), '0);
        check("gate_no_evt", WIDTH'(evt_valid), '0);
        fault = 3'b000; enable = 1'b1;
        tick();

        // overflow
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            fault = 3'b001 << (k % 3); voted_q = WIDTH'(k + 1);
            if (k < 4) expect_evt(fault, voted_q);
            tick();
            fault = 3'b000;
            tick();
        end
        check("ovf_sticky_set", WIDTH'(ovf_sticky), WIDTH'(1'b1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_sticky_clr", WIDTH'(ovf_sticky), '0);
        check("ovf_fifo_kept", WIDTH'(evt_valid), WIDTH'(1'b1));
        evt_ready = 1'b1; fault = 3'b100; voted_q = 'h6; expect_evt(3'b100, 'h6);
        tick();
        evt_ready = 1'b0; fault = 3'b000;
        tick();
        check("full_pushpop_no_drop", WIDTH'(ovf_sticky), '0);
        evt_ready = 1'b1;
        tick(3);
        check("drain_3_valid", WIDTH'(evt_valid), WIDTH'(1'b1));
        tick();
        check("drain_4_empty", WIDTH'(evt_valid), '0);

        // uncorrectable
        evt_ready = 1'b0;
        fault = 3'b111; voted_q = 'h77; expect_evt(3'b111, 'h77);
        tick();
        fault = 3'b000;
        check("uncorr_sticky_set", WIDTH'(uncorr_sticky), WIDTH'(1'b1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("uncorr_sticky_clr", WIDTH'(uncorr_sticky), '0);
        check("uncorr_evt_kept", WIDTH'(evt_valid), WIDTH'(1'b1));
        evt_ready = 1'b1;
        tick(2);

        // saturation, then asynchronous reset mid-stream
        clr = 1'b1;
        tick();
        clr = 1'b0;
        fault = 3'b001; voted_q = 'h99; expect_evt(3'b001, 'h99);
        tick(300);
        check("sat_err_cnt", WIDTH'(err_cnt), WIDTH'(24'h0000FF));
        check("sat_failed", WIDTH'(replica_failed), WIDTH'(3'b001));
        evt_ready = 1'b0; fault = 3'b011; voted_q = 'h55;
        tick();
        check("pre_rst_valid", WIDTH'(evt_valid), WIDTH'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_evt_valid", WIDTH'(evt_valid), '0);
        check("arst_err_cnt", WIDTH'(err_cnt), '0);
        check("arst_failed", WIDTH'(replica_failed), '0);
        check("arst_payload", WIDTH'({evt_mask, evt_uncorr}), '0);
        check("arst_value", evt_value, '0);
        tick();
        check("exp_queue_empty", WIDTH'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
- Downstream consumer of the triplicated counter: takes the three per-replica fault flags and the voted count value.
- Classifies each replica as healthy, suspect or failed, and keeps saturating per-replica error counts.
- Logs fault events into a small FIFO that a host or scan logger drains over a valid/ready handshake.
- Also flags the uncorrectable case where no two replicas agree.

Parameters:
- WIDTH, 128, width of voted_q and of the logged value.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- PERSIST_CYCLES, 8, consecutive faulty enabled cycles before a replica is declared failed; range 2..255.
- CNT_W, 8, width of each saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  same enable that drives the counters; the monitor only samples when it is high
- fault  in  3  per-replica mismatch flags, bit i = replica i+1
- voted_q  in  WIDTH  voted counter value
- clr  in  1  synchronous clear of failed states, counters and sticky flags (FIFO untouched)
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_mask  out  3  fault bits of the head event
- evt_value  out  WIDTH  voted_q captured with the head event
- evt_uncorr  out  1  head event had all three fault bits set
- replica_failed  out  3  sticky per-replica failed flags
- err_cnt  out  3*CNT_W  saturating fault-cycle counts; replica 1 in the LSBs
- uncorr_sticky  out  1  sticky flag: fault==3'b111 seen
- ovf_sticky  out  1  sticky flag: event dropped because FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, FIFO empty, all replica FSMs in OK, persistence counters 0, fault_q=0.
  - Release is synchronised by the register path only; the first sampling edge is the first clk edge with rst_n high.
- Sampling: the monitor acts only on edges where enable=1. With enable=0, FSMs, counters and event generation hold; FIFO pops still proceed.
- Per-replica FSM (independent for i=0..2):
  - OK: fault[i]=1 -> SUSPECT, persist=1.
  - SUSPECT, fault[i]=1: persist+1; when persist reaches PERSIST_CYCLES -> FAILED and replica_failed[i]=1 on the same edge.
  - SUSPECT, fault[i]=0: -> OK, persist=0.
  - FAILED: sticky regardless of fault[i]; left only by clr (-> OK) or reset.
- err_cnt[i]: +1 on every enabled edge with fault[i]=1; saturates at 2^CNT_W-1, never wraps; clr zeroes it.
- Event generation, on an enabled edge:
  - An event is produced when (fault & ~fault_q) != 0, i.e. a new bit rises; fault_q is the previously sampled fault vector.
  - Payload = {fault, voted_q, fault==3'b111}.
  - A persistent fault yields one event, not one per cycle.
  - fault_q updates only on enabled edges.
- uncorr_sticky: set on an enabled edge with fault==3'b111, independent of event generation.
- FIFO:
  - Push when an event is produced and the FIFO is not full.
  - Pop when evt_valid and evt_ready.
  - Outputs reflect the head registered; an event written into an empty FIFO is visible on evt_valid the cycle after the edge that captured it (latency 1).
  - Push and pop on the same edge: allowed at any occupancy, including full (pop frees the slot, push succeeds, count unchanged).
  - Pop with the FIFO empty is ignored.
  - evt_valid=0 while empty; evt_mask, evt_value and evt_uncorr hold their last value and are don't-care.
- Overflow: if an event is produced while the FIFO is full and no pop occurs that edge, the event is dropped and ovf_sticky=1.
- clr, synchronous and taking priority over the same-edge increments and transitions:
  - clears replica FSMs, persist counters, err_cnt, uncorr_sticky and ovf_sticky.
  - does not clear fault_q or the FIFO.
- Reset mid-operation: all state is lost immediately, including queued events.

Optional Feature:
- Macro: TMR_MON_TSTAMP_EN.
- When defined:
  - adds a 32-bit free-running cycle counter (reset 0, wraps at 2^32, increments every clk regardless of enable).
  - adds output port evt_tstamp (32 bits), stored per FIFO entry: the counter value at the capturing edge.
- When undefined: no counter, no port, no extra storage.

Test Plan:
- Single glitch: reset, enable=1, fault=001 for 1 cycle with voted_q=0x10 -> one event {mask 001, value 0x10, uncorr 0}; err_cnt[0]=1; replica 1 back to OK; replica_failed=000.
- Persistence: fault=010 held 8 enabled cycles, PERSIST_CYCLES=8 -> replica_failed=010 after the 8th edge; exactly one event; err_cnt[1]=8; stays failed after fault clears until clr pulse.
- Enable gating: fault=100 held while enable=0 for 20 cycles -> no event, err_cnt unchanged, replica 3 still OK.
- Overflow: evt_ready=0, five rising events (001, 000, 010, 000, 100, ...) with FIFO_DEPTH=4 -> first 4 queued in order, 5th dropped, ovf_sticky=1. Then a same-edge push and pop at full -> count stays 4, no drop.
- Uncorrectable: fault=111 for one enabled cycle -> event with evt_uncorr=1 and uncorr_sticky=1; clr clears uncorr_sticky but the queued event remains.
- Saturation and reset: fault=001 held 300 cycles, CNT_W=8 -> err_cnt[0]=255 (no wrap). Assert rst_n low mid-stream -> all outputs 0 immediately, asynchronously.
